ssd_entry_scan: RTL

Controller for the board's 4-digit seven-segment display. It time-multiplexes four stored hex digits onto the shared anode and segment resource and scans them at a prescaled rate. It also sequences digit entry: each rising edge of the debounced `enter` level writes the 4-bit switch value into the digit under a wrapping cursor. It sits between the debouncer output and the `binary_to_segment` decoder, and replaces ad-hoc anode sequencing in top-level display logic.

---
 rtl/ssd_pkg.sv | 30 +++
 rtl/ssd_tick_gen.sv | 27 ++
 rtl/ssd_entry_scan.sv | 139 +++++++++++++
 3 files changed

// File: rtl/ssd_pkg.sv
// Shared seven-segment display constants: digit count, anode patterns and the digit type.
package ssd_pkg;

  localparam int unsigned SSD_DIGITS = 4;
  localparam int unsigned SSD_IDX_W  = 2;

  typedef logic [3:0]           digit_t;
  typedef logic [SSD_IDX_W-1:0] idx_t;

  // Active-low anode enables, one digit lit per pattern
  localparam logic [3:0] AN_IDX0 = 4'b0111;
  localparam logic [3:0] AN_IDX1 = 4'b1011;
  localparam logic [3:0] AN_IDX2 = 4'b1101;
  localparam logic [3:0] AN_IDX3 = 4'b1110;
  localparam logic [3:0] AN_OFF  = 4'b1111;

  function automatic logic [3:0] an_decode(input idx_t idx);
    logic [3:0] pat;
    pat = AN_OFF;
    case (idx)
      2'd0: pat = AN_IDX0;
      2'd1: pat = AN_IDX1;
      2'd2: pat = AN_IDX2;
      2'd3: pat = AN_IDX3;
      default: pat = AN_OFF;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/ssd_tick_gen.sv
// Prescaler: one-cycle tick_c every SCAN_DIV clocks (every clock when SCAN_DIV is 1).
module ssd_tick_gen #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic clk,
  input  logic reset,
  output logic tick_c
);

  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] count_q, count_d;

  assign tick_c = (count_q == CNT_MAX);

  always_comb begin
    count_d = count_q + CNT_W'(1);
    if (tick_c) count_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

endmodule

// File: rtl/ssd_entry_scan.sv
// Four-digit seven-segment scan plus cursor-based digit entry.
// Optional cursor blink blanking is compiled in with SSD_CURSOR_BLINK_EN.
module ssd_entry_scan
  import ssd_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLINK_FRAMES = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enter,
  input  logic        clear,
  input  logic [3:0]  digit_in,
  output logic [3:0]  an,
  output logic [3:0]  seg_nibble,
  output logic [1:0]  cursor,
  output logic [15:0] digits,
  output logic        entry_done
);

  if (SCAN_DIV < 1) begin : g_bad_scan_div
    $error("ssd_entry_scan: SCAN_DIV must be >= 1");
  end
  if (BLINK_FRAMES < 1) begin : g_bad_blink_frames
    $error("ssd_entry_scan: BLINK_FRAMES must be >= 1");
  end

  logic   tick_c;
  idx_t   scan_idx_q, scan_idx_d;
  logic [3:0] an_q, an_d;
  logic   blank_c;

  logic   enter_q;
  logic   wr_edge_c;
  digit_t digits_q [SSD_DIGITS];
  digit_t digits_d [SSD_DIGITS];
  idx_t   cursor_q, cursor_d;
  logic   last_wr_q, last_wr_d;
  logic   done_q, done_d;

  ssd_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .tick_c (tick_c)
  );

  // Entry path: clear wins over a same-cycle enter edge
  always_comb begin
    wr_edge_c = enter & ~enter_q;
    digits_d  = digits_q;
    cursor_d  = cursor_q;
    last_wr_d = 1'b0;
    done_d    = last_wr_q;
    if (clear) begin
      for (int i = 0; i < SSD_DIGITS; i++) digits_d[i] = '0;
      cursor_d = '0;
      done_d   = 1'b0;
    end else if (wr_edge_c) begin
      digits_d[cursor_q] = digit_in;
      cursor_d  = cursor_q + idx_t'(1);
      last_wr_d = (cursor_q == idx_t'(SSD_DIGITS - 1));
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      enter_q   <= 1'b1;
      cursor_q  <= '0;
      last_wr_q <= 1'b0;
      done_q    <= 1'b0;
      for (int i = 0; i < SSD_DIGITS; i++) digits_q[i] <= '0;
    end else begin
      enter_q   <= enter;
      cursor_q  <= cursor_d;
      last_wr_q <= last_wr_d;
      done_q    <= done_d;
      digits_q  <= digits_d;
    end
  end

`ifdef SSD_CURSOR_BLINK_EN
  localparam int unsigned FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [FRAME_W-1:0] frame_q, frame_d;
  logic               blink_off_q, blink_off_d;

  // Frame count advances on each 3->0 scan wrap; phase flips every BLINK_FRAMES frames
  always_comb begin
    frame_d     = frame_q;
    blink_off_d = blink_off_q;
    if (tick_c && (scan_idx_q == idx_t'(SSD_DIGITS - 1))) begin
      if (frame_q == FRAME_W'(BLINK_FRAMES - 1)) begin
        frame_d     = '0;
        blink_off_d = ~blink_off_q;
      end else begin
        frame_d = frame_q + FRAME_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      frame_q     <= '0;
      blink_off_q <= 1'b0;
    end else begin
      frame_q     <= frame_d;
      blink_off_q <= blink_off_d;
    end
  end

  assign blank_c = blink_off_d && (scan_idx_d == cursor_d);
`else
  assign blank_c = 1'b0;
`endif

  // Scan path: anode register tracks the next scan index so it changes on the tick edge
  always_comb begin
    scan_idx_d = scan_idx_q;
    if (tick_c) scan_idx_d = scan_idx_q + idx_t'(1);
    an_d = blank_c ? AN_OFF : an_decode(scan_idx_d);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      scan_idx_q <= '0;
      an_q       <= AN_IDX0;
    end else begin
      scan_idx_q <= scan_idx_d;
      an_q       <= an_d;
    end
  end

  assign an         = an_q;
  assign seg_nibble = digits_q[scan_idx_q];
  assign cursor     = cursor_q;
  assign digits     = {digits_q[0], digits_q[1], digits_q[2], digits_q[3]};
  assign entry_done = done_q;

endmodule
